// File: rtl/gps_round_sequencer_if.sv
// Result channel of the GPS round sequencer: valid/ready handshake plus the
// captured code payload for one satellite round.
interface gps_round_sequencer_if;
    logic         res_valid;
    logic         res_ready;
    logic [5:0]   res_sv;
    logic [12:0]  res_ca;
    logic [127:0] res_p;
    logic [127:0] res_l;
    logic         res_timeout;

    modport master (
        output res_valid, res_sv, res_ca, res_p, res_l, res_timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_sv, res_ca, res_p, res_l, res_timeout,
        output res_ready
    );
endinterface

// File: rtl/gps_round_sequencer.sv
// Steps through a latched SV schedule, kicks one gps round per entry and hands each
// captured result to the host. Optional GPS_SEQ_CONTINUOUS_EN: wrap to entry 0 while go=1.
module gps_round_sequencer #(
    parameter int unsigned NUM_SV  = 4,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  sys_clk_50,
    input  logic                  async_rst_n,
    input  logic                  go,
    input  logic [6*NUM_SV-1:0]   sv_list,
    output logic                  busy,
    output logic                  done,
    output logic [5:0]            sv_num,
    output logic                  start_round,
    input  logic [12:0]           ca_code,
    input  logic [127:0]          p_code,
    input  logic [127:0]          l_code,
    input  logic                  l_code_valid,
    gps_round_sequencer_if.master res
);
    localparam int unsigned IW = (NUM_SV > 1)  ? $clog2(NUM_SV)  : 1;
    localparam int unsigned SW = (SETTLE > 1)  ? $clog2(SETTLE)  : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_SV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_LOW, S_WAIT_HIGH, S_RESULT
    } state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_SV-1:0][5:0]  list_q, list_d;
    logic [SW-1:0]           set_q, set_d;
    logic [TW-1:0]           to_q, to_d;
    logic [5:0]              res_sv_q, res_sv_d;
    logic [12:0]             res_ca_q, res_ca_d;
    logic [127:0]            res_p_q, res_p_d;
    logic [127:0]            res_l_q, res_l_d;
    logic                    res_to_q, res_to_d;
    logic                    done_q, done_d;

    always_ff @(posedge sys_clk_50 or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            list_q   <= '0;
            set_q    <= '0;
            to_q     <= '0;
            res_sv_q <= '0;
            res_ca_q <= '0;
            res_p_q  <= '0;
            res_l_q  <= '0;
            res_to_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            list_q   <= list_d;
            set_q    <= set_d;
            to_q     <= to_d;
            res_sv_q <= res_sv_d;
            res_ca_q <= res_ca_d;
            res_p_q  <= res_p_d;
            res_l_q  <= res_l_d;
            res_to_q <= res_to_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        list_d   = list_q;
        set_d    = set_q;
        to_d     = to_q;
        res_sv_d = res_sv_q;
        res_ca_d = res_ca_q;
        res_p_d  = res_p_q;
        res_l_d  = res_l_q;
        res_to_d = res_to_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    list_d  = sv_list;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (set_q == SETTLE_LAST) state_d = S_START;
                else                      set_d   = set_q + 1'b1;
            end
            // Settle counter is re-armed here, so every LOAD entry starts from zero.
            S_START: begin
                set_d   = '0;
                to_d    = '0;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW, S_WAIT_HIGH: begin
                to_d = to_q + 1'b1;
                if (state_q == S_WAIT_HIGH && l_code_valid) begin
                    res_sv_d = sv_num;
                    res_ca_d = ca_code;
                    res_p_d  = p_code;
                    res_l_d  = l_code;
                    res_to_d = 1'b0;
                    state_d  = S_RESULT;
                end else if (to_q == TO_LAST) begin
                    res_sv_d = sv_num;
                    res_ca_d = '0;
                    res_p_d  = '0;
                    res_l_d  = '0;
                    res_to_d = 1'b1;
                    state_d  = S_RESULT;
                end else if (state_q == S_WAIT_LOW && !l_code_valid) begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_RESULT: begin
                if (res.res_ready) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        done_d = 1'b1;
`ifdef GPS_SEQ_CONTINUOUS_EN
                        if (go) begin
                            idx_d   = '0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy            = (state_q != S_IDLE);
    assign start_round     = (state_q == S_START);
    assign done            = done_q;
    assign sv_num          = list_q[idx_q];
    assign res.res_valid   = (state_q == S_RESULT);
    assign res.res_sv      = res_sv_q;
    assign res.res_ca      = res_ca_q;
    assign res.res_p       = res_p_q;
    assign res.res_l       = res_l_q;
    assign res.res_timeout = res_to_q;
endmodule

// File: tb/tb_gps_round_sequencer.sv
// Bench for gps_round_sequencer: a gps stub with planned per-round latencies, a
// timestamp-based reference model compared every cycle, and directed scenarios.
module tb_gps_round_sequencer;
    localparam int NUM_SV  = 4;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1024;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic                go    = 1'b0;
    logic [6*NUM_SV-1:0] sv_list = '0;
    logic                busy, done, start_round;
    logic [5:0]          sv_num;
    logic [12:0]         ca;
    logic [127:0]        p, l;
    logic                lv;

    gps_round_sequencer_if rif ();

    gps_round_sequencer #(.NUM_SV(NUM_SV), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk_50   (clk),
        .async_rst_n  (rst_n),
        .go           (go),
        .sv_list      (sv_list),
        .busy         (busy),
        .done         (done),
        .sv_num       (sv_num),
        .start_round  (start_round),
        .ca_code      (ca),
        .p_code       (p),
        .l_code       (l),
        .l_code_valid (lv),
        .res          (rif)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Golden code functions standing in for the gps core.
    function automatic logic [12:0] f_ca(input logic [5:0] sv);
        return {sv, sv ^ 6'h15, 1'b1} ^ 13'h0ABC;
    endfunction
    function automatic logic [127:0] f_p(input logic [5:0] sv);
        logic [31:0] w;
        w = 32'h9E3779B9 * (32'(sv) + 32'd1);
        return {w, ~w, w ^ 32'h5A5A5A5A, w[15:0], w[31:16]};
    endfunction
    function automatic logic [127:0] f_l(input logic [127:0] pv);
        return {pv[63:0], pv[127:64]} ^ 128'h0123456789ABCDEFFEDCBA9876543210;
    endfunction

    // Per-round stub plan: stale-valid hold e, rise delay d, or never.
    int pe [256];
    int pd [256];
    bit pn [256];
    int sk = 0;

    int         s_s, s_e, s_d;
    bit         s_never;
    bit         s_have = 1'b0;
    logic [5:0] s_sv;

    always @(negedge clk) begin
        if (!rst_n) s_have = 1'b0;
        else if (start_round) begin
            s_s     = cyc;
            s_e     = pe[sk % 256];
            s_d     = pd[sk % 256];
            s_never = pn[sk % 256];
            s_sv    = sv_num;
            s_have  = 1'b1;
            sk++;
        end
    end

    initial begin
        lv = 1'b0; ca = '0; p = '0; l = '0;
        forever begin
            step();
            if (s_have) begin
                if (cyc == s_s + 1 + s_e) lv = 1'b0;
                if (!s_never && cyc == s_s + 1 + s_e + s_d) begin
                    lv = 1'b1;
                    ca = f_ca(s_sv);
                    p  = f_p(s_sv);
                    l  = f_l(f_p(s_sv));
                end
            end
            if (!lv) begin
                ca = 13'($urandom);
                p  = {$urandom, $urandom, $urandom, $urandom};
                l  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Reference model: event timestamps derived from the schedule rules.
    logic [5:0]   ml [NUM_SV];
    int           m_idx = 0, t_start = -1, t_res = -1, m_done_at = -1, mk = 0;
    bit           m_busy = 1'b0;
    logic [5:0]   m_sv = '0, m_rsv = '0, q_sv = '0;
    logic [12:0]  m_rca = '0, q_ca = '0;
    logic [127:0] m_rp = '0, m_rl = '0, q_p = '0, q_l = '0;
    logic         m_rto = 1'b0, q_to = 1'b0;
    bit           e_start, e_rv, e_done;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_sv = '0; m_idx = 0;
            t_start = -1; t_res = -1; m_done_at = -1;
            m_rsv = '0; m_rca = '0; m_rp = '0; m_rl = '0; m_rto = 1'b0;
        end else if (m_busy && cyc == t_res) begin
            m_rsv = q_sv; m_rca = q_ca; m_rp = q_p; m_rl = q_l; m_rto = q_to;
        end
        e_start = m_busy && cyc == t_start;
        e_rv    = m_busy && t_res >= 0 && cyc >= t_res;
        e_done  = (cyc == m_done_at);

        chk("busy",        busy,            m_busy);
        chk("start_round", start_round,     e_start);
        chk("res_valid",   rif.res_valid,   e_rv);
        chk("done",        done,            e_done);
        chk("sv_num",      sv_num,          m_sv);
        chk("res_sv",      rif.res_sv,      m_rsv);
        chk("res_ca",      rif.res_ca,      m_rca);
        chk("res_p",       rif.res_p,       m_rp);
        chk("res_l",       rif.res_l,       m_rl);
        chk("res_timeout", rif.res_timeout, m_rto);

        if (rst_n) begin
            if (!m_busy) begin
                if (go) begin
                    for (int i = 0; i < NUM_SV; i++) ml[i] = sv_list[6*i +: 6];
                    m_busy = 1'b1; m_idx = 0; m_sv = ml[0];
                    t_start = cyc + 1 + SETTLE; t_res = -1;
                end
            end else begin
                if (cyc == t_start) begin
                    if (pn[mk % 256]) begin
                        t_res = cyc + 1 + TIMEOUT;
                        q_sv = m_sv; q_ca = '0; q_p = '0; q_l = '0; q_to = 1'b1;
                    end else begin
                        t_res = cyc + 2 + pe[mk % 256] + pd[mk % 256];
                        q_sv = m_sv; q_ca = f_ca(m_sv); q_p = f_p(m_sv); q_l = f_l(f_p(m_sv)); q_to = 1'b0;
                    end
                    mk++;
                end
                if (e_rv && rif.res_ready) begin
                    t_res = -1;
                    if (m_idx < NUM_SV - 1) begin
                        m_idx++; m_sv = ml[m_idx]; t_start = cyc + 1 + SETTLE;
                    end else begin
                        m_done_at = cyc + 1;
`ifdef GPS_SEQ_CONTINUOUS_EN
                        if (go) begin
                            m_idx = 0; m_sv = ml[0]; t_start = cyc + 1 + SETTLE;
                        end else begin
                            m_busy = 1'b0;
                        end
`else
                        m_busy = 1'b0;
`endif
                    end
                end
            end
        end
    end

    task automatic drain();
        go = 1'b0;
        rif.res_ready = 1'b1;
        for (int k = 0; k < 6000 && busy; k++) step();
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    int                  g, ts, tr, nres, dcount, starts, held, nst;
    logic [5:0]          rsv [8];
    logic                rto;
    logic [12:0]         cas [4];
    logic [127:0]        ps [4];
    logic [127:0]        snap_p;
    logic [5:0]          snap_sv;
    logic [6*NUM_SV-1:0] lst;

    initial begin
        for (int i = 0; i < 256; i++) begin
            pe[i] = $urandom_range(0, 3);
            pd[i] = $urandom_range(1, 20);
            pn[i] = ($urandom_range(0, 15) == 0);
        end
        rif.res_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_busy",      busy,          1'b0);
        chk("rst_res_valid", rif.res_valid, 1'b0);
        chk("rst_sv_num",    sv_num,        6'd0);
        chk("rst_res_l",     rif.res_l,     128'd0);
        rst_n = 1'b1;
        step();

        // Pass 1: fixed schedule SV1..SV4, always ready.
        for (int i = 0; i < 4; i++) pn[(sk + i) % 256] = 1'b0;
        sv_list = {6'd4, 6'd3, 6'd2, 6'd1};
        rif.res_ready = 1'b1;
        go = 1'b1; g = cyc;
        step();
        go = 1'b0;
        sv_list = 24'($urandom);
        ts = -1; nres = 0; dcount = 0; rto = 1'b0;
        for (int k = 0; k < 2000 && !(dcount > 0 && !busy); k++) begin
            if (start_round && ts < 0) ts = cyc;
            if (rif.res_valid && rif.res_ready && nres < 8) begin
                rsv[nres] = rif.res_sv; rto |= rif.res_timeout; nres++;
            end
            if (done) dcount++;
            step();
        end
        chk("p1_start_delay", ts - g, 5);
        chk("p1_nres", nres, 4);
        chk("p1_sv0", rsv[0], 6'd1);
        chk("p1_sv1", rsv[1], 6'd2);
        chk("p1_sv2", rsv[2], 6'd3);
        chk("p1_sv3", rsv[3], 6'd4);
        chk("p1_timeout", rto, 1'b0);
        chk("p1_done_cnt", dcount, 1);
        chk("p1_busy_after", busy, 1'b0);

        // Pass 2: back-pressure on the first result.
        rif.res_ready = 1'b0;
        sv_list = 24'($urandom);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int k = 0; k < 1500 && !rif.res_valid; k++) step();
        chk("bp_reach", rif.res_valid, 1'b1);
        snap_p = rif.res_p; snap_sv = sv_num; starts = 0; held = 0;
        repeat (50) begin
            step();
            if (start_round) starts++;
            if (rif.res_valid) held++;
        end
        chk("bp_starts", starts, 0);
        chk("bp_held", held, 50);
        chk("bp_res_p", rif.res_p, snap_p);
        chk("bp_sv_num", sv_num, snap_sv);
        drain();

        // Pass 3: first entry never gets l_code_valid.
        pn[sk % 256] = 1'b1;
        lst = 24'($urandom);
        sv_list = lst;
        go = 1'b1;
        step();
        go = 1'b0;
        ts = -1; tr = -1;
        for (int k = 0; k < 100; k++) begin
            if (start_round) begin ts = cyc; break; end
            step();
        end
        for (int k = 0; k < 1200; k++) begin
            step();
            if (rif.res_valid) begin tr = cyc; break; end
        end
        chk("to_latency", tr - ts, 1025);
        chk("to_flag", rif.res_timeout, 1'b1);
        chk("to_res_l", rif.res_l, 128'd0);
        chk("to_res_sv", rif.res_sv, lst[5:0]);
        drain();

        // Pass 4: repeated SVs with go pulses while busy.
        for (int i = 0; i < 4; i++) pn[(sk + i) % 256] = 1'b0;
        sv_list = {6'd7, 6'd7, 6'd9, 6'd9};
        go = 1'b1;
        step();
        nres = 0;
        for (int k = 0; k < 3000 && nres < 4; k++) begin
            go = ($urandom_range(0, 2) == 0);
            if (rif.res_valid && rif.res_ready) begin
                cas[nres] = rif.res_ca; ps[nres] = rif.res_p; nres++;
                if (nres == 4) go = 1'b0;
            end
            step();
        end
        go = 1'b0;
        chk("rep_nres", nres, 4);
        chk("rep_ca01", cas[0], cas[1]);
        chk("rep_p01", ps[0], ps[1]);
        chk("rep_ca23", cas[2], cas[3]);
        chk("rep_ca0_val", cas[0], f_ca(6'd9));
        drain();

        // Pass 5: asynchronous reset during WAIT_HIGH of entry 2.
        for (int i = 0; i < 3; i++) pn[(sk + i) % 256] = 1'b0;
        pe[(sk + 2) % 256] = 0;
        pd[(sk + 2) % 256] = 20;
        rif.res_ready = 1'b1;
        sv_list = 24'($urandom);
        go = 1'b1;
        step();
        go = 1'b0;
        nst = 0;
        for (int k = 0; k < 3000; k++) begin
            if (start_round) begin
                nst++;
                if (nst == 3) break;
            end
            step();
        end
        chk("rst_mid_reach", nst, 3);
        repeat (6) step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rstm_busy",      busy,            1'b0);
        chk("rstm_start",     start_round,     1'b0);
        chk("rstm_done",      done,            1'b0);
        chk("rstm_res_valid", rif.res_valid,   1'b0);
        chk("rstm_sv_num",    sv_num,          6'd0);
        chk("rstm_res_sv",    rif.res_sv,      6'd0);
        chk("rstm_res_ca",    rif.res_ca,      13'd0);
        chk("rstm_res_p",     rif.res_p,       128'd0);
        chk("rstm_res_l",     rif.res_l,       128'd0);
        chk("rstm_timeout",   rif.res_timeout, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        lst = 24'($urandom);
        sv_list = lst;
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        chk("rst_restart_sv", sv_num, lst[5:0]);
        chk("rst_restart_busy", busy, 1'b1);
        drain();

        // Random traffic.
        for (int k = 0; k < 12000; k++) begin
            sv_list = 24'($urandom);
            go = ($urandom_range(0, 3) == 0);
            rif.res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
